// File: rtl/whack_window_timer.sv
// whack_window_timer: N_CH independent mole response windows driven by one
// shared tick prescaler. Each channel is armed with the current window
// length, counts down on ticks, and closes with a hit (press) or miss
// (timeout). The window length can be shortened with shrink pulses.
// Optional feature macro: WHACK_FALSE_PRESS_EN (adds false_press output and
// blocks a shrink that coincides with a false press).
module whack_window_timer #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned INIT_WINDOW = 5,
    parameter int unsigned MIN_WINDOW  = 1,
    parameter int unsigned SHRINK_STEP = 1
) (
    input  logic                    systemClock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         pressed,
    input  logic                    shrink,
    output logic [N_CH*CNT_W-1:0]   timer,
    output logic [N_CH-1:0]         active,
    output logic [N_CH-1:0]         hit,
    output logic [N_CH-1:0]         miss,
    output logic [CNT_W-1:0]        window,
    output logic                    tick
`ifdef WHACK_FALSE_PRESS_EN
    ,
    output logic [N_CH-1:0]         false_press
`endif
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_MAX       = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] WIN_INIT     = CNT_W'(INIT_WINDOW);
    localparam logic [CNT_W-1:0] WIN_MIN      = CNT_W'(MIN_WINDOW);
    localparam logic [CNT_W-1:0] WIN_STEP     = CNT_W'(SHRINK_STEP);
    localparam logic [CNT_W:0]   SHRINK_FLOOR = (CNT_W+1)'(MIN_WINDOW + SHRINK_STEP);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [PS_W-1:0]        r_presc;
    logic                   r_tick;
    logic [CNT_W-1:0]       r_window;
    logic [N_CH-1:0]        r_state;
    logic [N_CH*CNT_W-1:0]  r_timer;
    logic [N_CH-1:0]        r_hit;
    logic [N_CH-1:0]        r_miss;

    logic                   w_tick_now;
    logic                   w_shrink_ok;
    logic [CNT_W:0]         w_win_ext;
    logic [CNT_W-1:0]       w_window_shrunk;

    assign w_tick_now = enable && (r_presc == '0);

    // Next window value after one shrink, clamped at the floor without wrapping
    always_comb begin
        w_win_ext = {1'b0, r_window};
        if (w_win_ext >= SHRINK_FLOOR) begin
            w_window_shrunk = r_window - WIN_STEP;
        end else begin
            w_window_shrunk = WIN_MIN;
        end
    end

`ifdef WHACK_FALSE_PRESS_EN
    logic [N_CH-1:0] r_false;
    logic [N_CH-1:0] w_false_now;

    // A press on an idle, non-arming channel while the game runs is a false press
    always_comb begin
        w_false_now = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_false_now[i] = enable && (r_state[i] == S_IDLE) && pressed[i] && !start[i];
        end
    end

    assign w_shrink_ok = shrink && !(|w_false_now);

    // Register false-press pulses
    always_ff @(posedge systemClock) begin
        if (reset) begin
            r_false <= '0;
        end else begin
            r_false <= w_false_now;
        end
    end

    assign false_press = r_false;
`else
    assign w_shrink_ok = shrink;
`endif

    // Shared prescaler: counts down to zero, held at reload while paused
    always_ff @(posedge systemClock) begin
        if (reset || !enable) begin
            r_presc <= PS_MAX;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_tick_now;
            if (w_tick_now) begin
                r_presc <= PS_MAX;
            end else begin
                r_presc <= r_presc - PS_W'(1);
            end
        end
    end

    // Window length register; shrink is honoured even while paused
    always_ff @(posedge systemClock) begin
        if (reset) begin
            r_window <= WIN_INIT;
        end else if (w_shrink_ok) begin
            r_window <= w_window_shrunk;
        end
    end

    // Per-channel IDLE/ACTIVE windows; press outranks a coincident final tick
    always_ff @(posedge systemClock) begin
        if (reset || !enable) begin
            r_state <= '0;
            r_timer <= '0;
            r_hit   <= '0;
            r_miss  <= '0;
        end else begin
            r_hit  <= '0;
            r_miss <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (r_state[i] == S_IDLE) begin
                    if (start[i]) begin
                        r_state[i]                 <= S_ACTIVE;
                        r_timer[i*CNT_W +: CNT_W]  <= r_window;
                    end
                end else begin
                    if (pressed[i]) begin
                        r_state[i]                 <= S_IDLE;
                        r_timer[i*CNT_W +: CNT_W]  <= '0;
                        r_hit[i]                   <= 1'b1;
                    end else if (w_tick_now && (r_timer[i*CNT_W +: CNT_W] == CNT_W'(1))) begin
                        r_state[i]                 <= S_IDLE;
                        r_timer[i*CNT_W +: CNT_W]  <= '0;
                        r_miss[i]                  <= 1'b1;
                    end else if (w_tick_now) begin
                        r_timer[i*CNT_W +: CNT_W]  <= r_timer[i*CNT_W +: CNT_W] - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign timer  = r_timer;
    assign active = r_state;
    assign hit    = r_hit;
    assign miss   = r_miss;
    assign window = r_window;
    assign tick   = r_tick;

endmodule

// File: tb/tb_whack_window_timer.sv
// Directed bench for whack_window_timer (TICK_DIV=4, N_CH=4, CNT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_whack_window_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  start;
    logic [3:0]  pressed;
    logic        shrink;
    logic [15:0] timer;
    logic [3:0]  active;
    logic [3:0]  hit;
    logic [3:0]  miss;
    logic [3:0]  window;
    logic        tick;
`ifdef WHACK_FALSE_PRESS_EN
    logic [3:0]  false_press;
`endif

    int errors = 0;
    int checks = 0;

    whack_window_timer #(
        .TICK_DIV    (4),
        .N_CH        (4),
        .CNT_W       (4),
        .INIT_WINDOW (5),
        .MIN_WINDOW  (1),
        .SHRINK_STEP (1)
    ) dut (
        .systemClock (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .pressed     (pressed),
        .shrink      (shrink),
        .timer       (timer),
        .active      (active),
        .hit         (hit),
        .miss        (miss),
        .window      (window),
        .tick        (tick)
`ifdef WHACK_FALSE_PRESS_EN
        ,
        .false_press (false_press)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef WHACK_FALSE_PRESS_EN
    localparam logic [3:0] W_AFTER_FALSE = 4'd5;
    localparam logic [3:0] FP_EXPECT     = 4'b0010;
`else
    localparam logic [3:0] W_AFTER_FALSE = 4'd4;
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; start = '0; pressed = '0; shrink = 1'b0;
        step(2);
        chk("rst_timer",  timer,  0);
        chk("rst_active", active, 0);
        chk("rst_hit",    hit,    0);
        chk("rst_miss",   miss,   0);
        chk("rst_window", window, 5);
        chk("rst_tick",   tick,   0);

        // 1: arm ch0, let it time out
        reset = 1'b0; enable = 1'b1; start = 4'b0001;
        step(1);                                   // A1
        start = '0;
        chk("t1_active", active, 4'b0001);
        chk("t1_load",   timer[3:0], 5);
        step(2);                                   // A3
        chk("t1_notick", tick, 0);
        chk("t1_hold5",  timer[3:0], 5);
        step(1);                                   // A4: first tick
        chk("t1_tick1",  tick, 1);
        chk("t1_cnt4",   timer[3:0], 4);
        step(1);                                   // A5
        chk("t1_tickpulse", tick, 0);
        step(3);                                   // A8
        chk("t1_cnt3",   timer[3:0], 3);
        step(4);                                   // A12
        chk("t1_cnt2",   timer[3:0], 2);
        step(4);                                   // A16
        chk("t1_cnt1",   timer[3:0], 1);
        chk("t1_nomiss", miss, 0);
        chk("t1_nohit",  hit, 0);
        step(4);                                   // A20
        chk("t1_miss",   miss, 4'b0001);
        chk("t1_hit0",   hit, 0);
        chk("t1_idle",   active, 0);
        chk("t1_tzero",  timer[3:0], 0);
        step(1);                                   // A21
        chk("t1_misspulse", miss, 0);

        // 2: arm ch1, press after two ticks
        start = 4'b0010;
        step(1);                                   // A22
        start = '0;
        chk("t2_load", timer[7:4], 5);
        step(2);                                   // A24
        chk("t2_cnt4", timer[7:4], 4);
        step(4);                                   // A28
        chk("t2_cnt3", timer[7:4], 3);
        pressed = 4'b0010;
        step(1);                                   // A29
        pressed = '0;
        chk("t2_hit",    hit, 4'b0010);
        chk("t2_nomiss", miss, 0);
        chk("t2_tzero",  timer[7:4], 0);
        chk("t2_idle",   active, 0);
        step(1);                                   // A30
        chk("t2_hitpulse", hit, 0);

        // 3: press coincident with final tick on ch2
        start = 4'b0100;
        step(1);                                   // A31
        start = '0;
        chk("t3_load", timer[11:8], 5);
        step(13);                                  // A44
        chk("t3_cnt1", timer[11:8], 1);
        step(3);                                   // A47
        pressed = 4'b0100;
        step(1);                                   // A48
        pressed = '0;
        chk("t3_hit",    hit, 4'b0100);
        chk("t3_nomiss", miss, 0);
        chk("t3_tick",   tick, 1);
        chk("t3_idle",   active, 0);
        step(1);                                   // A49
        chk("t3_late_miss", miss, 0);
        chk("t3_hitpulse",  hit, 0);

        // 4: shrink six times, floor at 1
        shrink = 1'b1;
        step(1); chk("t4_w4", window, 4);
        step(1); chk("t4_w3", window, 3);
        step(1); chk("t4_w2", window, 2);
        step(1); chk("t4_w1", window, 1);
        step(1); chk("t4_w1b", window, 1);
        step(1); chk("t4_w1c", window, 1);       // A55
        shrink = 1'b0;
        start = 4'b1000;
        step(1);                                   // A56
        start = '0;
        chk("t4_load1", timer[15:12], 1);
        step(3);                                   // A59
        chk("t4_open",  active, 4'b1000);
        step(1);                                   // A60
        chk("t4_miss",  miss, 4'b1000);
        chk("t4_idle",  active, 0);

        // 5: arm all, pause mid-window
        start = 4'b1111;
        step(1);                                   // A61
        start = '0;
        chk("t5_all_active", active, 4'b1111);
        chk("t5_all_timer",  timer, 16'h1111);
        step(1);
        enable = 1'b0;
        step(1);
        chk("t5_off_active", active, 0);
        chk("t5_off_timer",  timer, 0);
        chk("t5_off_hit",    hit, 0);
        chk("t5_off_miss",   miss, 0);
        chk("t5_window",     window, 1);
        step(5);
        chk("t5_quiet_miss", miss, 0);
        chk("t5_quiet_tick", tick, 0);

        // 6: reset mid-window, idle press, arm-cycle press, shrink on arm
        enable = 1'b1; start = 4'b0001;
        step(1);
        start = '0;
        chk("t6_armed", active, 4'b0001);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst_active", active, 0);
        chk("t6_rst_timer",  timer, 0);
        chk("t6_rst_window", window, 5);
        chk("t6_rst_hit",    hit, 0);
        pressed = 4'b0010; shrink = 1'b1;
        step(1);
        pressed = '0; shrink = 1'b0;
        chk("t6_idle_hit",    hit, 0);
        chk("t6_idle_active", active, 0);
        chk("t6_idle_window", window, W_AFTER_FALSE);
`ifdef WHACK_FALSE_PRESS_EN
        chk("t6_false",       false_press, FP_EXPECT);
`endif
        step(1);
`ifdef WHACK_FALSE_PRESS_EN
        chk("t6_false_pulse", false_press, 0);
`endif
        start = 4'b0001; pressed = 4'b0001; shrink = 1'b1;
        step(1);
        start = '0; pressed = '0; shrink = 1'b0;
        chk("t6_arm_active", active, 4'b0001);
        chk("t6_arm_nohit",  hit, 0);
        chk("t6_arm_oldwin", timer[3:0], W_AFTER_FALSE);
        chk("t6_arm_shrunk", window, W_AFTER_FALSE - 4'd1);
`ifdef WHACK_FALSE_PRESS_EN
        chk("t6_arm_nofalse", false_press, 0);
`endif
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
